reaction_timer: RTL

// - Player-side end of the starting-line sequence. It arms when the start lights begin, then waits for the lights-out pulse.
// - It measures the player's reaction in milliseconds from lights-out to the button press.
// - It flags jump starts (press before or coincident with lights-out) and timeouts.
// - It holds the result for the seven-segment display until the next race is armed.

---
 rtl/reaction_timer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/reaction_timer.sv
// Starting-line reaction timer: arms on i_arm, times lights-out to button press in ms,
// flags jump starts and timeouts. Optional best-time tracking via `define BEST_TIME_EN.
module reaction_timer #(
  parameter int TICKS_PER_MS = 50000,
  parameter int MAX_MS       = 9999
) (
  input  logic        i_clk,
  input  logic        i_rstN,
  input  logic        i_arm,
  input  logic        i_lightsOut,
  input  logic        i_button,
  output logic        o_busy,
  output logic        o_resultValid,
  output logic [13:0] o_reactionMs,
  output logic        o_jumpStart,
  output logic        o_timeout,
  output logic [13:0] o_bestMs
);

  localparam int              PW     = $clog2(TICKS_PER_MS);
  localparam logic [13:0]     C_MAX  = 14'(MAX_MS);
  localparam logic [PW-1:0]   C_PMAX = PW'(TICKS_PER_MS - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ARMED  = 2'd1,
    S_TIMING = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_presc;
  logic [13:0]   r_ms;
  logic          r_button_q;
  logic          r_busy;
  logic          r_valid;
  logic [13:0]   r_reaction;
  logic          r_jump;
  logic          r_timeout;

  logic          w_press;
  logic          w_sat;
  logic          w_clear;
  logic          w_conclude;
  logic          w_jump;
  logic          w_tmo;
  logic [13:0]   w_result;

  assign w_press = i_button & ~r_button_q;
  assign w_sat   = (r_ms == C_MAX);

  // Next-state and result selection
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_conclude = 1'b0;
    w_jump     = 1'b0;
    w_tmo      = 1'b0;
    w_result   = r_ms;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (i_arm) begin
          w_next  = S_ARMED;
          w_clear = 1'b1;
        end else begin
          w_next = r_state;
        end
      end
      S_ARMED: begin
        if (w_press) begin
          w_next     = S_DONE;
          w_conclude = 1'b1;
          w_jump     = 1'b1;
          w_result   = 14'd0;
        end else if (i_lightsOut) begin
          w_next = S_TIMING;
        end else begin
          w_next = S_ARMED;
        end
      end
      S_TIMING: begin
        // A press on the saturating cycle takes priority over the timeout
        if (w_press) begin
          w_next     = S_DONE;
          w_conclude = 1'b1;
          w_result   = r_ms;
        end else if (w_sat) begin
          w_next     = S_DONE;
          w_conclude = 1'b1;
          w_tmo      = 1'b1;
          w_result   = C_MAX;
        end else begin
          w_next = S_TIMING;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, status and result registers
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_state    <= S_IDLE;
      r_button_q <= 1'b0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_reaction <= 14'd0;
      r_jump     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_button_q <= i_button;
      r_busy     <= (w_next == S_ARMED) || (w_next == S_TIMING);
      r_valid    <= w_conclude;
      if (w_clear) begin
        r_reaction <= 14'd0;
        r_jump     <= 1'b0;
        r_timeout  <= 1'b0;
      end else if (w_conclude) begin
        r_reaction <= w_result;
        r_jump     <= w_jump;
        r_timeout  <= w_tmo;
      end else begin
        r_reaction <= r_reaction;
      end
    end
  end

  // Prescaler and saturating ms counter, held at zero outside TIMING
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_presc <= '0;
      r_ms    <= 14'd0;
    end else if (r_state != S_TIMING) begin
      r_presc <= '0;
      r_ms    <= 14'd0;
    end else if (r_presc == C_PMAX) begin
      r_presc <= '0;
      if (r_ms != C_MAX) begin
        r_ms <= r_ms + 14'd1;
      end else begin
        r_ms <= r_ms;
      end
    end else begin
      r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
    end
  end

`ifdef BEST_TIME_EN
  logic [13:0] r_best;

  // Lowest valid reaction since reset; ties keep the old value
  always_ff @(posedge i_clk) begin
    if (!i_rstN) begin
      r_best <= C_MAX;
    end else if (w_conclude && !w_jump && !w_tmo && (w_result < r_best)) begin
      r_best <= w_result;
    end else begin
      r_best <= r_best;
    end
  end

  assign o_bestMs = r_best;
`else
  assign o_bestMs = C_MAX;
`endif

  assign o_busy        = r_busy;
  assign o_resultValid = r_valid;
  assign o_reactionMs  = r_reaction;
  assign o_jumpStart   = r_jump;
  assign o_timeout     = r_timeout;

endmodule
